// File: rtl/sort_pkg.sv
// Shared FSM encoding and compare-direction constants for the odd-even
// transposition sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange element: routes (a, b) to (lo_slot, hi_slot) in the
// order the requested direction wants. Equal keys stay in place.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             desc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_slot,
  output logic [WIDTH-1:0] hi_slot,
  output logic             swapped
);

  assign swapped = (desc == DIR_DESC) ? (a < b) : (a > b);
  assign lo_slot = swapped ? b : a;
  assign hi_slot = swapped ? a : b;

endmodule

// File: rtl/sort_n.sv
// Batch sorter: latches DEPTH keys, runs DEPTH odd-even transposition phases
// (one per cycle), then holds the result until the consumer takes it.
module sort_n
  import sort_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3,
  parameter int CNTW  = $clog2(DEPTH*DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  input  logic                   in_desc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*DEPTH-1:0] out_data,
  output logic [CNTW-1:0]        swap_cnt
);

  localparam int             PW   = $clog2(DEPTH);
  localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

  state_e                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   keys_q, keys_d, step;
  logic                          desc_q, desc_d;
  logic [PW-1:0]                 phase_q, phase_d;
  logic [CNTW-1:0]               cnt_q, cnt_d;
  logic [CNTW:0]                 nsw, sum;

  logic [DEPTH-2:0][WIDTH-1:0]   lo_w, hi_w;
  logic [DEPTH-2:0]              sw_w;

  // One element per adjacent pair; even-k pairs serve even phases, odd-k
  // pairs serve odd phases, so each phase sees its own bank.
  for (genvar k = 0; k < DEPTH-1; k++) begin : g_cmp
    sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
      .desc    (desc_q),
      .a       (keys_q[k]),
      .b       (keys_q[k+1]),
      .lo_slot (lo_w[k]),
      .hi_slot (hi_w[k]),
      .swapped (sw_w[k])
    );
  end

  always_comb begin
    step = keys_q;
    nsw  = '0;
    for (int k = 0; k < DEPTH-1; k++) begin
      if ((k % 2) == int'(phase_q[0])) begin
        step[k]   = lo_w[k];
        step[k+1] = hi_w[k];
        nsw       = nsw + {{CNTW{1'b0}}, sw_w[k]};
      end
    end
    sum = {1'b0, cnt_q} + nsw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = SORT;
      SORT:    if (phase_q == LAST) state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = keys_q;
    swap_cnt  = cnt_q;
  end

  always_comb begin
    keys_d  = keys_q;
    desc_d  = desc_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        keys_d  = in_data;
        desc_d  = in_desc;
        phase_d = '0;
        cnt_d   = '0;
      end
      SORT: begin
        keys_d  = step;
        phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
        cnt_d   = sum[CNTW] ? '1 : sum[CNTW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_q  <= '0;
      desc_q  <= DIR_ASC;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      keys_q  <= keys_d;
      desc_q  <= desc_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sort_n.sv
// Self-checking bench for sort_n: an 8x8 instance for directed/random work,
// a 3x3 instance for the exhaustive sweep, and a 3x3 copy with a 1-bit counter.
module tb_sort_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int acc_cyc  = 0;
  bit b_hold   = 1'b0;

  logic        b_iv, b_ir, b_id, b_ov, b_or;
  logic [63:0] b_idata, b_od;
  logic [6:0]  b_cnt;

  logic        s_iv, s_ir, s_id, s_ov, s_or;
  logic [8:0]  s_idata, s_od;
  logic [4:0]  s_cnt;

  logic        t_ir, t_ov;
  logic [8:0]  t_od;
  logic [0:0]  t_cnt;

  sort_n #(.WIDTH(8), .DEPTH(8)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_idata),
    .in_desc(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .swap_cnt(b_cnt)
  );

  sort_n #(.WIDTH(3), .DEPTH(3)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_idata),
    .in_desc(s_id), .out_valid(s_ov), .out_ready(s_or), .out_data(s_od),
    .swap_cnt(s_cnt)
  );

  sort_n #(.WIDTH(3), .DEPTH(3), .CNTW(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(t_ir), .in_data(s_idata),
    .in_desc(s_id), .out_valid(t_ov), .out_ready(s_or), .out_data(t_od),
    .swap_cnt(t_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input logic [63:0] v, input int i, input int w);
    return int'((v >> (i*w)) & ((64'd1 << w) - 64'd1));
  endfunction

  // Reference result: the keys fully sorted in the requested order.
  function automatic logic [63:0] ref_sort(input logic [63:0] v, input int d,
                                           input int w, input bit desc);
    int q[$];
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < d; i++) q.push_back(key(v, i, w));
    if (desc) q.rsort();
    else      q.sort();
    for (int i = 0; i < d; i++) r = r | (64'(q[i]) << (i*w));
    return r;
  endfunction

  // Each adjacent strict exchange removes exactly one inversion, and the
  // result is fully sorted, so the exchange count is the inversion count.
  function automatic int ref_inv(input logic [63:0] v, input int d,
                                 input int w, input bit desc);
    int n;
    n = 0;
    for (int i = 0; i < d; i++)
      for (int j = i + 1; j < d; j++)
        if (desc ? (key(v, i, w) < key(v, j, w)) : (key(v, i, w) > key(v, j, w)))
          n++;
    return n;
  endfunction

  task automatic run_big(input logic [63:0] data, input bit desc,
                         input int stall, input bit gap_chk);
    logic [63:0] exp;
    int lat, w;
    exp = ref_sort(data, 8, 8, desc);
    w = 0;
    while (!b_ir && w < 40) begin @(posedge clk); #1; w++; end
    chk("big_ready_wait", 64'(b_ir), 64'd1);
    b_iv = 1'b1; b_idata = data; b_id = desc;
    @(posedge clk); #1;
    if (gap_chk) chk("b2b_gap", 64'(cyc - acc_cyc), 64'd10);
    acc_cyc = cyc;
    // Garbage offered while busy must be ignored.
    b_idata = {$urandom, $urandom};
    b_id    = 1'($urandom);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (b_ov) lat = c;
    end
    chk("big_latency", 64'(lat), 64'd8);
    chk("big_data", b_od, exp);
    chk("big_swaps", 64'(b_cnt), 64'(ref_inv(data, 8, 8, desc)));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_data", b_od, exp);
      chk("stall_ready", 64'(b_ir), 64'd0);
      chk("stall_valid", 64'(b_ov), 64'd1);
    end
    b_or = 1'b1;
    @(posedge clk); #1;
    b_or = b_hold;
    chk("big_pop_ready", 64'(b_ir), 64'd1);
    chk("big_pop_valid", 64'(b_ov), 64'd0);
    b_iv = 1'b0;
  endtask

  task automatic run_small(input logic [8:0] data, input bit desc);
    int lat, n;
    n = ref_inv(64'(data), 3, 3, desc);
    s_iv = 1'b1; s_idata = data; s_id = desc;
    @(posedge clk); #1;
    s_iv = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (s_ov) lat = c;
    end
    chk("small_latency", 64'(lat), 64'd3);
    chk("small_data", 64'(s_od), ref_sort(64'(data), 3, 3, desc));
    chk("small_swaps", 64'(s_cnt), 64'(n));
    chk("sat_data", 64'(t_od), ref_sort(64'(data), 3, 3, desc));
    chk("sat_swaps", 64'(t_cnt), (n > 0) ? 64'd1 : 64'd0);
    s_or = 1'b1;
    @(posedge clk); #1;
    s_or = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rev, fives, d;
    bit seen;
    b_iv = 0; b_id = 0; b_or = 0; b_idata = '0;
    s_iv = 0; s_id = 0; s_or = 0; s_idata = '0;
    for (int i = 0; i < 8; i++) begin
      rev[i*8 +: 8]   = 8'(7 - i);
      fives[i*8 +: 8] = 8'd5;
    end

    #1;
    chk("rst_in_ready", 64'(b_ir), 64'd1);
    chk("rst_out_valid", 64'(b_ov), 64'd0);
    chk("rst_out_data", b_od, 64'd0);
    chk("rst_swap_cnt", 64'(b_cnt), 64'd0);
    chk("rst_small_data", 64'(s_od), 64'd0);
    #11 rst = 1'b1;

    // First accept on the first rising edge after release.
    run_big(rev, 1'b0, 0, 1'b0);
    chk("rev_asc_const", b_od, 64'h0706050403020100);
    run_big(rev, 1'b1, 0, 1'b0);
    run_big(fives, 1'b0, 10, 1'b0);
    run_big(fives, 1'b1, 0, 1'b0);

    // Reset in the middle of SORT discards the batch.
    b_iv = 1'b1; b_idata = {$urandom, $urandom}; b_id = 1'b0;
    @(posedge clk); #1;
    b_iv = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(b_ir), 64'd1);
    chk("midrst_out_valid", 64'(b_ov), 64'd0);
    chk("midrst_out_data", b_od, 64'd0);
    chk("midrst_swap_cnt", 64'(b_cnt), 64'd0);
    #2 rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b_ov || !b_ir) seen = 1'b1;
    end
    chk("midrst_no_output", 64'(seen), 64'd0);
    run_big({$urandom, $urandom}, 1'b0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom};
      if (n % 2 == 1) d = d & 64'h0303030303030303;
      run_big(d, 1'($urandom), 0, 1'b0);
    end

    b_hold = 1'b1;
    b_or   = 1'b1;
    run_big({$urandom, $urandom}, 1'($urandom), 0, 1'b0);
    for (int n = 0; n < 4; n++) run_big({$urandom, $urandom}, 1'($urandom), 0, 1'b1);
    b_hold = 1'b0;
    b_or   = 1'b0;

    for (int v = 0; v < 512; v++) run_small(9'(v), 1'b0);
    for (int n = 0; n < 30; n++) run_small(9'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
